regfile_sequencer: RTL
======================

# regfile_sequencer

Multi-cycle command sequencer that sits in front of the 8-entry (R1–R4, S1–S4) 32-bit register file. It accepts one register-transfer command at a time over a valid/ready handshake and drives the register file's read selects, function select, write enables and write-data input cycle by cycle. It supports load, move, clear, three-cycle swap through scratch S4, and N-step increment. Completion is reported with a one-cycle done pulse and an error flag.

## Interface
- No parameters; data width fixed at 32, register index width fixed at 3.
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- CmdValid  in  1  command present
- CmdReady  out  1  sequencer can accept a command
- Cmd  in  3  000 LOAD, 001 MOVE, 010 SWAP, 011 CLEAR, 100 INCN, others illegal
- SrcA  in  3  source index (0–3 = R1–R4, 4–7 = S1–S4)
- Dst  in  3  destination index, same encoding
- Data  in  32  LOAD value; INCN uses Data[3:0] as count N
- RfOutA  in  32  register file OutA (feedback)
- RfOutASel  out  3  register file OutA select
- RfOutBSel  out  3  register file OutB select (always latched Dst)
- RfFunSel  out  3  000 decrement, 001 increment, 010 load, 011 clear
- RfRegSel  out  4  write enables; bit3 = R1 … bit0 = R4
- RfScrSel  out  4  write enables; bit3 = S1 … bit0 = S4
- RfI  out  32  register file write data
- Busy  out  1  command in progress (not IDLE)
- Done  out  1  one-cycle completion pulse
- Err  out  1  valid only with Done; 1 = command rejected, no write performed

## Operation
- States: IDLE, EXEC, SWAP1, SWAP2, SWAP3, INC, DONE.
- IDLE: CmdReady=1. On CmdValid&&CmdReady, latch Cmd, SrcA, Dst, Data; go to EXEC (LOAD/MOVE/CLEAR), SWAP1 (SWAP), INC (INCN, N≠0), DONE (INCN, N=0), or DONE with error (illegal Cmd, or SWAP with SrcA or Dst = 7).
- Index decode: idx 0–3 → RfRegSel one-hot at bit (3−idx); idx 4–7 → RfScrSel one-hot at bit (7−idx). At most one enable bit high in any cycle.
- EXEC: LOAD: FunSel=010, RfI=Data, enable Dst. MOVE: RfOutASel=SrcA, RfI=RfOutA, FunSel=010, enable Dst. CLEAR: FunSel=011, enable Dst. Then → DONE.
- SWAP1: RfOutASel=SrcA, RfI=RfOutA, load S4. SWAP2: RfOutASel=Dst, load SrcA. SWAP3: RfOutASel=7, load Dst. Then → DONE. SrcA=Dst is legal; net value unchanged.
- INC: FunSel=001, enable Dst, 4-bit counter loaded with N at accept, decremented each INC cycle; leave to DONE after the cycle in which the counter is 1. Register wrap-around (0xFFFFFFFF+1 = 0) is the register's behaviour, not flagged.
- DONE: Done=1, Err per latched error; no enables; → IDLE.
- Outside write cycles: all enables 0, RfFunSel=010, RfOutASel=latched SrcA, RfI=Data.
- Enables are combinational from state/latched operands and gated with ~Reset.

## Timing
- Command accepted at edge 0: LOAD/MOVE/CLEAR write at edge 1, Done high cycle 1→2, CmdReady high again from edge 2.
- SWAP: writes at edges 1, 2, 3; Done in cycle after edge 3; total 5 cycles accept-to-next-accept.
- INCN: N writes at edges 1..N; Done in following cycle. N=0: Done in cycle after edge 0, no write.
- Error: Done=Err=1 in cycle after edge 0, zero enables throughout.
- CmdValid while Busy is ignored (CmdReady=0); no queueing.
- Reset values (during and after reset edge): state IDLE, CmdReady=0 while Reset high then 1, Busy=0, Done=0, Err=0, all enables 0, RfFunSel=010, selects 0, RfI=0.
- Reset mid-command: no register file write on the reset edge; partial SWAP/INCN results already written stay; no Done emitted.

## Test plan
- LOAD Dst=2, Data=0x12345678 → R3 enable high one cycle, Done cycle 2, Err=0; OutB (Dst sel) reads 0x12345678.
- R1=0xA, R2=0xB; SWAP SrcA=0, Dst=1 → S4 load, R1 load, R2 load on edges 1–3; R1=0xB, R2=0xA, S4=0xA, Done in cycle 4.
- R4=0xFFFFFFFE; INCN Dst=3, N=3 → three increment cycles, R4=0x00000001, Done cycle 4; INCN N=0 → Done cycle 1, no enable.
- Cmd=111 and SWAP with Dst=7 → Done=Err=1 next cycle, RfRegSel=RfScrSel=0 throughout.
- Reset asserted during SWAP2 → no write that edge, state IDLE, Done never pulses, CmdReady=1 after reset drops; CmdValid held during Busy is not accepted until IDLE.

Source files
------------

// File: rtl/regfile_sequencer.sv
// Purpose: command sequencer in front of the 8 x 32-bit register file (R1-R4, S1-S4).
//   It runs LOAD / MOVE / CLEAR / SWAP (through S4) / INCN and drives the register file's controls.
// Latency: accept at edge 0; LOAD/MOVE/CLEAR write at edge 1, SWAP at edges 1-3, INCN at edges 1..N;
//   Done pulses in the cycle after the last write, or after edge 0 on error or N=0.
// Backpressure: CmdReady is high only in IDLE, so a command is not accepted while Busy and is not queued.
// Ports:
//   Clock/Reset          clock; synchronous active-high reset
//   CmdValid/CmdReady    command handshake
//   Cmd/SrcA/Dst/Data    command operands
//   RfOutA               read-back of the register file OutA port
//   RfOutASel/RfOutBSel  register file read selects
//   RfFunSel             register file function select
//   RfRegSel/RfScrSel    write enables for R1-R4 and S1-S4
//   RfI                  register file write data
//   Busy/Done/Err        status outputs
module regfile_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [2:0]  Cmd,
  input  logic [2:0]  SrcA,
  input  logic [2:0]  Dst,
  input  logic [31:0] Data,
  input  logic [31:0] RfOutA,
  output logic [2:0]  RfOutASel,
  output logic [2:0]  RfOutBSel,
  output logic [2:0]  RfFunSel,
  output logic [3:0]  RfRegSel,
  output logic [3:0]  RfScrSel,
  output logic [31:0] RfI,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_SWAP1, S_SWAP2, S_SWAP3, S_INC, S_DONE
  } state_t;

  localparam logic [2:0] CMD_LOAD  = 3'b000;
  localparam logic [2:0] CMD_MOVE  = 3'b001;
  localparam logic [2:0] CMD_SWAP  = 3'b010;
  localparam logic [2:0] CMD_CLEAR = 3'b011;
  localparam logic [2:0] CMD_INCN  = 3'b100;

  localparam logic [2:0] FUN_INC   = 3'b001;
  localparam logic [2:0] FUN_LOAD  = 3'b010;
  localparam logic [2:0] FUN_CLR   = 3'b011;

  localparam logic [2:0] IDX_S4    = 3'd7;

  state_t      state_q, state_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [2:0]  src_q, src_d;
  logic [2:0]  dst_q, dst_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        accept;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [2:0]  fun;
  logic [2:0]  asel;
  logic [31:0] rfi;
  logic [7:0]  en8;

  assign CmdReady = (state_q == S_IDLE) && !Reset;
  assign accept   = CmdValid && CmdReady;

  // Next-state and operand latching
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_d  = Cmd;
          src_d  = SrcA;
          dst_d  = Dst;
          data_d = Data;
          cnt_d  = Data[3:0];
          err_d  = 1'b0;
          case (Cmd)
            CMD_LOAD, CMD_MOVE, CMD_CLEAR: state_d = S_EXEC;
            CMD_SWAP: begin
              // S4 is the swap scratch, so it cannot be an operand
              if (SrcA == IDX_S4 || Dst == IDX_S4) begin
                err_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                state_d = S_SWAP1;
              end
            end
            CMD_INCN: state_d = (Data[3:0] == 4'd0) ? S_DONE : S_INC;
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_EXEC:  state_d = S_DONE;
      S_SWAP1: state_d = S_SWAP2;
      S_SWAP2: state_d = S_SWAP3;
      S_SWAP3: state_d = S_DONE;
      S_INC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cmd_q   <= 3'd0;
      src_q   <= 3'd0;
      dst_q   <= 3'd0;
      data_q  <= 32'd0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Per-state register file controls; the defaults are the idle values
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = dst_q;
    fun    = FUN_LOAD;
    asel   = src_q;
    rfi    = data_q;
    case (state_q)
      S_EXEC: begin
        wr_en = 1'b1;
        case (cmd_q)
          CMD_MOVE:  rfi = RfOutA;
          CMD_CLEAR: fun = FUN_CLR;
          default:   rfi = data_q;
        endcase
      end
      S_SWAP1: begin
        wr_en  = 1'b1;
        wr_idx = IDX_S4;
        rfi    = RfOutA;
      end
      S_SWAP2: begin
        wr_en  = 1'b1;
        wr_idx = src_q;
        asel   = dst_q;
        rfi    = RfOutA;
      end
      S_SWAP3: begin
        wr_en  = 1'b1;
        asel   = IDX_S4;
        rfi    = RfOutA;
      end
      S_INC: begin
        wr_en = 1'b1;
        fun   = FUN_INC;
      end
      default: wr_en = 1'b0;
    endcase
  end

  // The index maps onto {RegSel,ScrSel} as bit (7-idx): R1 is bit 7 and S4 is bit 0.
  // Gating with Reset blocks any write on a reset edge in the middle of a command.
  assign en8                  = (wr_en && !Reset) ? (8'h80 >> wr_idx) : 8'h00;
  assign {RfRegSel, RfScrSel} = en8;

  assign RfFunSel  = Reset ? FUN_LOAD : fun;
  assign RfOutASel = Reset ? 3'd0 : asel;
  assign RfOutBSel = Reset ? 3'd0 : dst_q;
  assign RfI       = Reset ? 32'd0 : rfi;
  assign Busy      = (state_q != S_IDLE) && !Reset;
  assign Done      = (state_q == S_DONE) && !Reset;
  assign Err       = Done && err_q;

endmodule
